riscv_fetch_unit: RTL

Instruction fetch front end that supplies instructions to the RISC-V execute core. It generates sequential PCs, issues word reads over a valid/ready memory request channel, and accepts in-order read responses. Responses are buffered in a small FIFO and presented to the core as {instr, pc} over a valid/ready handshake. A redirect input supports branch and jump targets: it flushes buffered and in-flight instructions and restarts fetch at the new PC.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/riscv_fetch_unit_if.sv | 28 ++
 rtl/fetch_fifo.sv | 51 +++++
 rtl/riscv_fetch_unit.sv | 87 ++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V widths, opcodes and fetch entry type
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    // Major opcodes, instr[6:0]
    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] S_TYPE = 7'b0100011;
    localparam logic [6:0] B_TYPE = 7'b1100011;
    localparam logic [6:0] U_TYPE = 7'b0110111;
    localparam logic [6:0] J_TYPE = 7'b1101111;
    localparam logic [6:0] LOAD   = 7'b0000011;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_unit_if.sv
// rtl/riscv_fetch_unit_if.sv - memory, core and redirect channels of the fetch unit
interface riscv_fetch_unit_if #(
    parameter int XLEN = 32
) ();
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_resp_valid;
    logic [XLEN-1:0] mem_resp_data;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, instr_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc,
        output mem_req_ready, mem_resp_valid, mem_resp_data, instr_ready,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of fetch entries with flush
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            do_push;
    logic            do_pop;

    // Flush wins over both ports; a full FIFO still accepts a push paired with a pop.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && do_push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/riscv_fetch_unit.sv
// rtl/riscv_fetch_unit.sv - sequential instruction fetch with credit flow control and redirect flush
module riscv_fetch_unit #(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
    input  logic                      clk,
    input  logic                      rst,
    riscv_fetch_unit_if.master        bus
);
    localparam int CW = $clog2(DEPTH+1);

    logic [XLEN-1:0]         fetch_pc;
    logic [XLEN-1:0]         resp_pc;
    logic [XLEN-1:0]         redirect_target;
    logic [CW-1:0]           outstanding;
    logic [CW-1:0]           outstanding_next;
    logic [CW-1:0]           drop_cnt;
    logic [CW-1:0]           fifo_count;
    logic [CW:0]             credit_used;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    req_hs;
    logic                    push;
    logic                    pop;
    logic                    unused_redirect_bits;
    riscv_pkg::fetch_entry_t push_entry;
    riscv_pkg::fetch_entry_t head;

    assign redirect_target      = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_bits = ^bus.redirect_pc[1:0];

    // Every request holds a FIFO slot from issue until the core pops it, so pushes never overflow.
    assign credit_used       = {1'b0, outstanding} + {1'b0, fifo_count};
    assign bus.mem_req_valid = rst && !bus.redirect_valid && (credit_used < (CW+1)'(DEPTH));
    assign bus.mem_req_addr  = fetch_pc;
    assign req_hs            = bus.mem_req_valid && bus.mem_req_ready;

    assign outstanding_next  = outstanding + CW'(req_hs) - CW'(bus.mem_resp_valid);

    assign push       = rst && bus.mem_resp_valid && !bus.redirect_valid && (drop_cnt == '0);
    assign pop        = bus.instr_valid && bus.instr_ready && !bus.redirect_valid;
    assign push_entry = '{instr: bus.mem_resp_data, pc: resp_pc};

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (bus.redirect_valid) begin
                // Everything still in flight after this edge belongs to the old stream.
                fetch_pc <= redirect_target;
                resp_pc  <= redirect_target;
                drop_cnt <= outstanding_next;
            end else begin
                if (req_hs) fetch_pc <= fetch_pc + XLEN'(4);
                if (push)   resp_pc  <= resp_pc + XLEN'(4);
                if (bus.mem_resp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (bus.redirect_valid),
        .head      (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign bus.instr_valid = !fifo_empty;
    assign bus.instr       = fifo_empty ? '0 : head.instr;
    assign bus.instr_pc    = fifo_empty ? '0 : head.pc;

    no_push_when_full: assert property (@(posedge clk) disable iff (!rst) !(push && fifo_full));

endmodule
